// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/execute/commit sequencer that drives the PC update interface.
// Fetches over a req/ack handshake, hands the word to execute, then commits one PC write.
module fetch_sequencer #(
    parameter int unsigned              POINTER_LEN = 16,
    parameter int unsigned              DATA_LEN    = 16,
    parameter int unsigned              WAIT_MAX    = 15,
    parameter logic [DATA_LEN-1:0]      HALT_OPCODE = DATA_LEN'(16'hFFFF)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [POINTER_LEN-1:0] instruction_ptr,
    output logic                   mem_req,
    output logic [POINTER_LEN-1:0] mem_addr,
    input  logic                   mem_ack,
    input  logic [DATA_LEN-1:0]    mem_rdata,
    output logic [DATA_LEN-1:0]    instr,
    output logic                   instr_valid,
    input  logic                   exec_done,
    input  logic                   branch_taken,
    input  logic [POINTER_LEN-1:0] branch_target,
    output logic                   pc_wr_en,
    output logic                   pc_src,
    output logic [POINTER_LEN-1:0] pc_data,
    output logic                   halted,
    output logic                   fetch_err
);

    localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_EXEC   = 3'd1,
        S_UPDATE = 3'd2,
        S_HALT   = 3'd3,
        S_ERROR  = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       wait_q, wait_d;
    logic [DATA_LEN-1:0]    instr_q, instr_d;
    logic                   taken_q, taken_d;
    logic [POINTER_LEN-1:0] target_q, target_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FETCH;
            wait_q   <= '0;
            instr_q  <= '0;
            taken_q  <= 1'b0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            instr_q  <= instr_d;
            taken_q  <= taken_d;
            target_q <= target_d;
        end
    end

    // Next-state: an ack on the last allowed wait cycle takes priority over the timeout.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        instr_d  = instr_q;
        taken_d  = taken_q;
        target_d = target_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ack) begin
                    instr_d = mem_rdata;
                    wait_d  = '0;
                    state_d = (mem_rdata == HALT_OPCODE) ? S_HALT : S_EXEC;
                end else if (wait_q == CNT_W'(WAIT_MAX - 1)) begin
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    taken_d  = branch_taken;
                    target_d = branch_target;
                    state_d  = S_UPDATE;
                end
            end
            S_UPDATE: begin
                wait_d  = '0;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_FETCH;
        endcase
    end

    // Moore decode; the request is held off while reset is asserted.
    always_comb begin
        mem_req     = (state_q == S_FETCH) && !rst;
        mem_addr    = mem_req ? instruction_ptr : '0;
        instr       = instr_q;
        instr_valid = (state_q == S_EXEC);
        pc_wr_en    = (state_q == S_UPDATE);
        pc_src      = (state_q == S_UPDATE) && taken_q;
        pc_data     = target_q;
        halted      = (state_q == S_HALT);
        fetch_err   = (state_q == S_ERROR);
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer: a per-instruction transaction model predicts
// every cycle's outputs, plus literal checks of reset, addresses, branch, timeout and halt.
module tb_fetch_sequencer;

    localparam int unsigned WMAX = 4;
    localparam logic [15:0] HALT = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instruction_ptr;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] instr;
    logic        instr_valid;
    logic        exec_done;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        pc_wr_en;
    logic        pc_src;
    logic [15:0] pc_data;
    logic        halted;
    logic        fetch_err;

    fetch_sequencer #(
        .POINTER_LEN (16),
        .DATA_LEN    (16),
        .WAIT_MAX    (WMAX),
        .HALT_OPCODE (HALT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .instruction_ptr (instruction_ptr),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .instr           (instr),
        .instr_valid     (instr_valid),
        .exec_done       (exec_done),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .pc_wr_en        (pc_wr_en),
        .pc_src          (pc_src),
        .pc_data         (pc_data),
        .halted          (halted),
        .fetch_err       (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        mem_req;
        logic [15:0] mem_addr;
        logic [15:0] instr;
        logic        instr_valid;
        logic        pc_wr_en;
        logic        pc_src;
        logic [15:0] pc_data;
        logic        halted;
        logic        fetch_err;
    } exp_t;

    int          checks   = 0;
    int          failures = 0;
    int          cyc_cnt  = 0;
    bit          exp_active = 1'b0;
    exp_t        exp_q;

    // Model state: architectural PC, last fetched word, last latched branch target.
    logic [15:0] pc;
    logic [15:0] m_instr;
    logic [15:0] m_target;

    logic [15:0] last_mem_addr;
    logic        last_pc_src;
    logic [15:0] last_pc_data;
    logic [15:0] ack_addrs[$];
    int          wr_cycles[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, expv, $time);
        end
    endtask

    function automatic exp_t ex(input bit req, input bit valid, input bit wr,
                                input bit src, input bit h, input bit er);
        exp_t e;
        e.mem_req     = req;
        e.mem_addr    = pc;
        e.instr       = m_instr;
        e.instr_valid = valid;
        e.pc_wr_en    = wr;
        e.pc_src      = src;
        e.pc_data     = m_target;
        e.halted      = h;
        e.fetch_err   = er;
        return e;
    endfunction

    // Single per-cycle compare against the model's expectation.
    always @(negedge clk) begin
        if (exp_active && !rst) begin
            chk("mem_req", 32'(mem_req), 32'(exp_q.mem_req));
            if (exp_q.mem_req) chk("mem_addr", 32'(mem_addr), 32'(exp_q.mem_addr));
            chk("instr", 32'(instr), 32'(exp_q.instr));
            chk("instr_valid", 32'(instr_valid), 32'(exp_q.instr_valid));
            chk("pc_wr_en", 32'(pc_wr_en), 32'(exp_q.pc_wr_en));
            chk("pc_src", 32'(pc_src), 32'(exp_q.pc_src));
            chk("pc_data", 32'(pc_data), 32'(exp_q.pc_data));
            chk("halted", 32'(halted), 32'(exp_q.halted));
            chk("fetch_err", 32'(fetch_err), 32'(exp_q.fetch_err));
            if (pc_wr_en) wr_cycles.push_back(cyc_cnt);
        end
    end

    task automatic cyc(input exp_t e);
        exp_q      = e;
        exp_active = 1'b1;
        @(negedge clk);
        last_mem_addr = mem_addr;
        last_pc_src   = pc_src;
        last_pc_data  = pc_data;
        @(posedge clk);
        #1;
        cyc_cnt++;
    endtask

    task automatic noise();
        mem_ack       = 1'($urandom);
        mem_rdata     = 16'($urandom);
        exec_done     = 1'($urandom);
        branch_taken  = 1'($urandom);
        branch_target = 16'($urandom);
    endtask

    // One instruction: d unacked fetch cycles, e stalled execute cycles, then commit.
    task automatic do_instr(input int d, input int e, input bit tk, input logic [15:0] tgt,
                            input logic [15:0] word, input bit done_in_fetch,
                            input bit stop_in_exec);
        int n;
        n = (d < int'(WMAX)) ? d : int'(WMAX);
        for (int i = 0; i < n; i++) begin
            noise();
            mem_ack = 1'b0;
            if (done_in_fetch) exec_done = 1'b1;
            cyc(ex(1, 0, 0, 0, 0, 0));
        end
        if (d >= int'(WMAX)) begin
            repeat (10) begin
                noise();
                cyc(ex(0, 0, 0, 0, 0, 1));
            end
            return;
        end
        noise();
        mem_ack   = 1'b1;
        mem_rdata = word;
        if (done_in_fetch) exec_done = 1'b1;
        cyc(ex(1, 0, 0, 0, 0, 0));
        ack_addrs.push_back(last_mem_addr);
        m_instr = word;
        if (word == HALT) begin
            repeat (20) begin
                noise();
                cyc(ex(0, 0, 0, 0, 1, 0));
            end
            return;
        end
        for (int j = 0; j < e; j++) begin
            noise();
            exec_done = 1'b0;
            cyc(ex(0, 1, 0, 0, 0, 0));
        end
        if (stop_in_exec) return;
        noise();
        exec_done     = 1'b1;
        branch_taken  = tk;
        branch_target = tgt;
        cyc(ex(0, 1, 0, 0, 0, 0));
        m_target = tgt;
        noise();
        cyc(ex(0, 0, 1, tk, 0, 0));
        pc = tk ? tgt : pc + 16'd1;
        instruction_ptr = pc;
    endtask

    // Asynchronous reset mid-cycle, outputs must clear at once and restart in fetch.
    task automatic do_reset(input string tag);
        exp_active = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk({tag, "_rst_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_rst_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_rst_instr"}, 32'(instr), 32'd0);
        chk({tag, "_rst_instr_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_rst_pc_wr_en"}, 32'(pc_wr_en), 32'd0);
        chk({tag, "_rst_pc_src"}, 32'(pc_src), 32'd0);
        chk({tag, "_rst_pc_data"}, 32'(pc_data), 32'd0);
        chk({tag, "_rst_halted"}, 32'(halted), 32'd0);
        chk({tag, "_rst_fetch_err"}, 32'(fetch_err), 32'd0);
        mem_ack   = 1'b0;
        exec_done = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk({tag, "_rel_mem_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_rel_mem_addr"}, 32'(mem_addr), 32'(pc));
        chk({tag, "_rel_halted"}, 32'(halted), 32'd0);
        chk({tag, "_rel_fetch_err"}, 32'(fetch_err), 32'd0);
        m_instr  = '0;
        m_target = '0;
    endtask

    initial begin
        rst             = 1'b1;
        pc              = 16'h0000;
        m_instr         = '0;
        m_target        = '0;
        instruction_ptr = pc;
        mem_ack         = 1'b0;
        mem_rdata       = '0;
        exec_done       = 1'b0;
        branch_taken    = 1'b0;
        branch_target   = '0;

        @(posedge clk);
        #1;
        chk("init_mem_req", 32'(mem_req), 32'd0);
        chk("init_instr_valid", 32'(instr_valid), 32'd0);
        chk("init_pc_wr_en", 32'(pc_wr_en), 32'd0);
        chk("init_fetch_err", 32'(fetch_err), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("init_rel_mem_req", 32'(mem_req), 32'd1);
        chk("init_rel_mem_addr", 32'(mem_addr), 32'h0000);

        // Back-to-back sequential instructions at full throughput.
        for (int k = 0; k < 4; k++) do_instr(0, 0, 1'b0, 16'($urandom), 16'h1234, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) chk("seq_addr", 32'(ack_addrs[k]), 32'(k));
        chk("seq_period_a", 32'(wr_cycles[1] - wr_cycles[0]), 32'd3);
        chk("seq_period_b", 32'(wr_cycles[3] - wr_cycles[2]), 32'd3);

        // Taken branch from PC=2.
        pc = 16'h0002;
        instruction_ptr = pc;
        do_instr(0, 0, 1'b1, 16'h0040, 16'h1234, 1'b0, 1'b0);
        chk("br_pc_src", 32'(last_pc_src), 32'd1);
        chk("br_pc_data", 32'(last_pc_data), 32'h0040);
        do_instr(0, 0, 1'b0, 16'h0000, 16'h1234, 1'b0, 1'b0);
        chk("br_next_addr", 32'(ack_addrs[ack_addrs.size() - 1]), 32'h0040);

        // Stall in execute with spurious exec_done during fetch.
        do_instr(2, 10, 1'b0, 16'h0101, 16'h0BEE, 1'b1, 1'b0);

        // Timeout boundary: ack on the last allowed cycle, then a real timeout.
        do_instr(3, 0, 1'b0, 16'h0000, 16'hA5A5, 1'b0, 1'b0);
        chk("to3_no_err", 32'(fetch_err), 32'd0);
        do_instr(4, 0, 1'b0, 16'h0000, 16'hA5A5, 1'b0, 1'b0);
        chk("to4_err", 32'(fetch_err), 32'd1);
        chk("to4_no_req", 32'(mem_req), 32'd0);
        do_reset("err");

        // Reset while waiting in execute.
        do_instr(1, 3, 1'b0, 16'h0000, 16'h5A5A, 1'b0, 1'b1);
        chk("exec_pre_valid", 32'(instr_valid), 32'd1);
        do_reset("exec");

        // Halt opcode.
        do_instr(1, 0, 1'b0, 16'h0000, HALT, 1'b0, 1'b0);
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_instr", 32'(instr), 32'hFFFF);
        do_reset("halt");

        // Randomized instruction stream.
        for (int k = 0; k < 40; k++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if (w == HALT) w = 16'h0000;
            do_instr(int'($urandom_range(0, WMAX - 1)), int'($urandom_range(0, 4)),
                     1'($urandom), 16'($urandom), w, 1'b0, 1'b0);
        end

        exp_active = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Multi-cycle fetch/commit controller that drives the program-counter update interface: it consumes the current instruction pointer and produces pc_wr_en, pc_src and the branch-target data.
Per instruction it fetches from instruction memory over a req/ack handshake, then presents the instruction to the execute stage and waits for completion. It then commits exactly one PC update (sequential or branch).
It also provides a fetch-timeout error and a halt state.

Parameters:
POINTER_LEN, 16, width of instruction_ptr, mem_addr, branch_target, pc_data
DATA_LEN, 16, width of instruction word (mem_rdata, instr)
WAIT_MAX, 15, max cycles mem_req may stay unacknowledged before error (>=1)
HALT_OPCODE, 16'hFFFF, instruction word that halts the sequencer

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
instruction_ptr  input  POINTER_LEN  current PC value
mem_req  output  1  instruction read request
mem_addr  output  POINTER_LEN  read address
mem_ack  input  1  read data valid this cycle
mem_rdata  input  DATA_LEN  read data, sampled when mem_ack=1
instr  output  DATA_LEN  latched instruction
instr_valid  output  1  instr valid for execute stage
exec_done  input  1  execute stage finished current instr
branch_taken  input  1  sampled with exec_done
branch_target  input  POINTER_LEN  sampled with exec_done
pc_wr_en  output  1  PC write strobe
pc_src  output  1  1=load pc_data, 0=increment
pc_data  output  POINTER_LEN  branch target to PC
halted  output  1  HALT_OPCODE fetched
fetch_err  output  1  fetch timeout, sticky

Behaviour:
- States: FETCH, EXEC, UPDATE, HALT, ERROR. Reset (async, rst=1) -> FETCH, wait_cnt=0, instr=0, latched taken=0, latched target=0.
- All outputs are 0 during reset, except that mem_req=1 and mem_addr=instruction_ptr hold as soon as rst deasserts (FETCH is the reset state).
- FETCH: mem_req=1, mem_addr=instruction_ptr (combinational pass-through). Outputs are Moore-style except mem_addr.
  - mem_ack=1: instr<=mem_rdata.
    - If mem_rdata==HALT_OPCODE -> HALT.
    - Otherwise -> EXEC.
  - mem_ack=0: wait_cnt++.
    - If wait_cnt==WAIT_MAX-1 -> ERROR (WAIT_MAX unacked request cycles).
    - An ack on the cycle wait_cnt==WAIT_MAX-1 wins over the timeout.
  - wait_cnt clears to 0 on every entry to FETCH.
- EXEC: instr_valid=1, mem_req=0.
  - exec_done=1: latch branch_taken and branch_target, then -> UPDATE.
  - No timeout in EXEC; it waits indefinitely.
- UPDATE: one cycle only, pc_wr_en=1, pc_src=latched taken, pc_data=latched target, instr_valid=0 -> FETCH.
  - PC is written at the end of UPDATE, so the new instruction_ptr is visible in the following FETCH.
- Throughput: with mem_ack in the first FETCH cycle and exec_done in the first EXEC cycle, an instruction takes 3 cycles.
- HALT: halted=1, mem_req=0, pc_wr_en=0, instr_valid=0. Exit only by reset.
- ERROR: fetch_err=1, mem_req=0, pc_wr_en=0. Exit only by reset.
- pc_data holds the last latched target outside UPDATE. pc_src=0 outside UPDATE.
- exec_done outside EXEC is ignored. mem_ack outside FETCH is ignored.
- Reset mid-operation (any state, any cycle) aborts immediately. No pc_wr_en pulse is emitted, and sticky flags clear.

Test Plan:
- Sequential: PC model starts 0, mem acks in 1 cycle with 16'h1234, exec_done in 1 cycle, branch_taken=0 -> pc_wr_en pulses every 3rd cycle with pc_src=0; mem_addr = 0,1,2,3.
- Branch: at PC=2, exec_done with branch_taken=1, branch_target=16'h0040 -> UPDATE shows pc_src=1, pc_data=16'h0040; next mem_addr=16'h0040.
- Timeout boundary: WAIT_MAX=4, ack withheld 3 cycles and given on the 4th -> instr captured, no error. Ack withheld 4 cycles -> fetch_err=1 on the next cycle, mem_req=0, no further pc_wr_en.
- Halt: mem_rdata=16'hFFFF with ack -> halted=1 next cycle, instr_valid never asserts, pc_wr_en stays 0 for 20 cycles.
- Stall: exec_done held low 10 cycles -> instr_valid high 10 cycles, no pc_wr_en. exec_done pulse while in FETCH is ignored.
- Reset mid-EXEC and mid-ERROR: assert rst asynchronously -> outputs clear immediately. After release, FETCH with mem_req=1, fetch_err=0, halted=0.
